// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer in front of a combinational SRAM wrapper.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module sram_arbiter #(
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_we,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_rdata,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_we,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_rdata,
  output logic                  o_sram_wren,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_wdata,
  input  logic [DATA_WIDTH-1:0] i_sram_rdata,
  output logic                  o_busy
);

  generate
    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 8) begin : g_bad_cycles
      $error("sram_arbiter: ACCESS_CYCLES must be in 1..8");
    end
  endgenerate

  localparam logic [2:0] CNT_INIT = 3'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t                r_state;
  logic [2:0]            r_cnt;
  logic                  r_owner;
  logic                  r_wren;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp0_valid;
  logic [DATA_WIDTH-1:0] r_rsp0_rdata;
  logic                  r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp1_rdata;
`ifdef SRAM_ARB_RR_EN
  logic                  r_last_grant;
`endif

  logic w_pick1;
  logic w_idle_ok;
  logic w_hs;

  // w_pick1 selects port 1 as the winner; only meaningful when some valid is high.
  always_comb begin
    w_pick1 = 1'b0;
`ifdef SRAM_ARB_RR_EN
    if (i_req0_valid && i_req1_valid) w_pick1 = (r_last_grant == 1'b0);
    else                              w_pick1 = i_req1_valid;
`else
    w_pick1 = i_req1_valid && !i_req0_valid;
`endif
  end

  assign w_idle_ok    = (r_state == IDLE) && !i_rst;
  assign o_req0_ready = w_idle_ok && i_req0_valid && !w_pick1;
  assign o_req1_ready = w_idle_ok && i_req1_valid && w_pick1;
  assign w_hs         = o_req0_ready || o_req1_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_wren       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_rdata <= '0;
`ifdef SRAM_ARB_RR_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_wren  <= w_pick1 ? i_req1_we    : i_req0_we;
            r_addr  <= w_pick1 ? i_req1_addr  : i_req0_addr;
            r_wdata <= w_pick1 ? i_req1_wdata : i_req0_wdata;
            r_cnt   <= CNT_INIT;
            r_owner <= w_pick1;
`ifdef SRAM_ARB_RR_EN
            r_last_grant <= w_pick1;
`endif
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          // Sample read data on the last held cycle, when the wrapper output has settled.
          if (r_cnt == 3'd0) begin
            if (!r_wren) begin
              if (r_owner) r_rsp1_rdata <= i_sram_rdata;
              else         r_rsp0_rdata <= i_sram_rdata;
            end
            if (r_owner) r_rsp1_valid <= 1'b1;
            else         r_rsp0_valid <= 1'b1;
            r_wren  <= 1'b0;
            r_state <= RECOVER;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RECOVER: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sram_wren  = r_wren;
  assign o_sram_addr  = r_addr;
  assign o_sram_wdata = r_wdata;
  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp0_rdata = r_rsp0_rdata;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp1_rdata = r_rsp1_rdata;
  assign o_busy       = (r_state != IDLE);

endmodule
